// File: rtl/matrix_session_ctrl_if.sv
// Bundle of the UART, matrix-memory and Calculator signals seen by the session sequencer.
// master is the sequencer side; slave is the surrounding top level.
interface matrix_session_ctrl_if #(
    parameter int unsigned MAX_N  = 3,
    parameter int unsigned RES_W  = 16,
    parameter int unsigned ADDR_W = 4
);
    logic                           rx_valid;
    logic [7:0]                     rx_data;
    logic                           tx_busy;
    logic                           tx_start;
    logic [7:0]                     tx_data;
    logic                           mem_clr;
    logic                           mem_a_we;
    logic                           mem_b_we;
    logic [ADDR_W-1:0]              mem_addr;
    logic                           mult_start;
    logic                           mult_done;
    logic [MAX_N*MAX_N*RES_W-1:0]   mult_result;
    logic [2:0]                     state;
    logic [3:0]                     matrix_size;
    logic                           err_size;
    logic                           err_overrun;

    modport master (
        input  rx_valid, rx_data, tx_busy, mult_done, mult_result,
        output tx_start, tx_data, mem_clr, mem_a_we, mem_b_we, mem_addr,
               mult_start, state, matrix_size, err_size, err_overrun
    );

    modport slave (
        output rx_valid, rx_data, tx_busy, mult_done, mult_result,
        input  tx_start, tx_data, mem_clr, mem_a_we, mem_b_we, mem_addr,
               mult_start, state, matrix_size, err_size, err_overrun
    );
endinterface

// File: rtl/matrix_session_ctrl.sv
// Session sequencer: receives n, matrix A and matrix B over UART, runs the Calculator,
// then streams the n x n results back high byte first through a start/busy handshake.
module matrix_session_ctrl #(
    parameter int unsigned MAX_N  = 3,
    parameter int unsigned RES_W  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input logic                   bclk,
    input logic                   rst,
    matrix_session_ctrl_if.master bus
);
    localparam int unsigned BPE = RES_W / 8;
    localparam int unsigned NEL = MAX_N * MAX_N;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RX_A      = 3'd1,
        RX_B      = 3'd2,
        COMPUTE   = 3'd3,
        WAIT      = 3'd4,
        SEND      = 3'd5,
        SEND_BUSY = 3'd6,
        SEND_IDLE = 3'd7
    } state_t;

    state_t                 state_q;
    logic [3:0]             size_q;
    logic [3:0]             row_q;
    logic [3:0]             col_q;
    logic [3:0]             sub_q;
    logic [NEL*RES_W-1:0]   shadow_q;
    logic                   tx_start_q;
    logic [7:0]             tx_data_q;
    logic                   mem_clr_q;
    logic                   mult_start_q;
    logic                   err_size_q;
    logic                   err_overrun_q;

    logic [3:0]             last_idx;
    logic                   col_last;
    logic                   row_last;
    logic                   sub_last;
    logic                   size_ok;
    logic                   busy_state;
    logic [ADDR_W-1:0]      addr;
    logic [RES_W-1:0]       elem;
    logic [RES_W-1:0]       elem_sh;
    logic [7:0]             cur_byte;

    // row/col double as the write position while receiving and the read position while sending
    always_comb begin
        last_idx   = size_q - 4'd1;
        col_last   = (col_q == last_idx);
        row_last   = (row_q == last_idx);
        sub_last   = (sub_q == 4'(BPE - 1));
        size_ok    = (bus.rx_data != 8'd0) && (bus.rx_data <= 8'(MAX_N));
        busy_state = (state_q == COMPUTE) || (state_q == WAIT) || (state_q == SEND) ||
                     (state_q == SEND_BUSY) || (state_q == SEND_IDLE);
        addr       = ADDR_W'(32'(row_q) * MAX_N + 32'(col_q));
        elem       = shadow_q[32'(addr) * RES_W +: RES_W];
        elem_sh    = elem >> ((32'(BPE - 1) - 32'(sub_q)) * 32'd8);
        cur_byte   = elem_sh[7:0];
    end

    assign bus.mem_addr    = addr;
    assign bus.mem_a_we    = (state_q == RX_A) && bus.rx_valid;
    assign bus.mem_b_we    = (state_q == RX_B) && bus.rx_valid;
    assign bus.mem_clr     = mem_clr_q;
    assign bus.mult_start  = mult_start_q;
    assign bus.tx_start    = tx_start_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.state       = state_q;
    assign bus.matrix_size = size_q;
    assign bus.err_size    = err_size_q;
    assign bus.err_overrun = err_overrun_q;

    always_ff @(posedge bclk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            size_q        <= '0;
            row_q         <= '0;
            col_q         <= '0;
            sub_q         <= '0;
            shadow_q      <= '0;
            tx_start_q    <= 1'b0;
            tx_data_q     <= '0;
            mem_clr_q     <= 1'b0;
            mult_start_q  <= 1'b0;
            err_size_q    <= 1'b0;
            err_overrun_q <= 1'b0;
        end else begin
            mem_clr_q    <= 1'b0;
            mult_start_q <= 1'b0;
            tx_start_q   <= 1'b0;
            err_size_q   <= 1'b0;
            if (bus.rx_valid && busy_state) begin
                err_overrun_q <= 1'b1;
            end

            unique case (state_q)
                IDLE: begin
                    if (bus.rx_valid) begin
                        if (size_ok) begin
                            size_q    <= bus.rx_data[3:0];
                            mem_clr_q <= 1'b1;
                            row_q     <= '0;
                            col_q     <= '0;
                            state_q   <= RX_A;
                        end else begin
                            err_size_q <= 1'b1;
                        end
                    end
                end
                RX_A, RX_B: begin
                    if (bus.rx_valid) begin
                        if (col_last) begin
                            col_q <= '0;
                            if (row_last) begin
                                row_q <= '0;
                                if (state_q == RX_A) begin
                                    state_q <= RX_B;
                                end else begin
                                    // registered so the strobe lines up with the COMPUTE cycle
                                    mult_start_q <= 1'b1;
                                    state_q      <= COMPUTE;
                                end
                            end else begin
                                row_q <= row_q + 4'd1;
                            end
                        end else begin
                            col_q <= col_q + 4'd1;
                        end
                    end
                end
                COMPUTE: begin
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (bus.mult_done) begin
                        shadow_q <= bus.mult_result;
                        row_q    <= '0;
                        col_q    <= '0;
                        sub_q    <= '0;
                        state_q  <= SEND;
                    end
                end
                SEND: begin
                    if (!bus.tx_busy) begin
                        tx_start_q <= 1'b1;
                        tx_data_q  <= cur_byte;
                        state_q    <= SEND_BUSY;
                    end
                end
                SEND_BUSY: begin
                    if (bus.tx_busy) begin
                        state_q <= SEND_IDLE;
                    end
                end
                SEND_IDLE: begin
                    if (!bus.tx_busy) begin
                        if (row_last && col_last && sub_last) begin
                            row_q         <= '0;
                            col_q         <= '0;
                            sub_q         <= '0;
                            err_overrun_q <= 1'b0;
                            state_q       <= IDLE;
                        end else begin
                            if (sub_last) begin
                                sub_q <= '0;
                                if (col_last) begin
                                    col_q <= '0;
                                    row_q <= row_q + 4'd1;
                                end else begin
                                    col_q <= col_q + 4'd1;
                                end
                            end else begin
                                sub_q <= sub_q + 4'd1;
                            end
                            state_q <= SEND;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_matrix_session_ctrl.sv
// Bench for matrix_session_ctrl: models UART, matrix memories and Calculator around the DUT
// and checks each session against a matrix product computed directly from the sent bytes.
module tb_matrix_session_ctrl;
    logic bclk = 1'b0;
    logic rst  = 1'b1;
    always #5 bclk = ~bclk;

    matrix_session_ctrl_if #(.MAX_N(3), .RES_W(16), .ADDR_W(4)) bus ();

    matrix_session_ctrl #(.MAX_N(3), .RES_W(16), .ADDR_W(4)) dut (
        .bclk(bclk),
        .rst (rst),
        .bus (bus)
    );

    logic         rx_valid_m    = 1'b0;
    logic [7:0]   rx_data_m     = 8'd0;
    logic         tx_busy_m     = 1'b0;
    logic         mult_done_m   = 1'b0;
    logic [143:0] mult_result_m = '0;
    assign bus.rx_valid    = rx_valid_m;
    assign bus.rx_data     = rx_data_m;
    assign bus.tx_busy     = tx_busy_m;
    assign bus.mult_done   = mult_done_m;
    assign bus.mult_result = mult_result_m;

    int tests_run    = 0;
    int tests_failed = 0;

    // environment knobs
    int rise_delay = 0;
    int busy_len   = 2;
    int calc_delay = 1;

    // environment observations
    logic [7:0] mem_a [9];
    logic [7:0] mem_b [9];
    logic [3:0] wr_a_log [$];
    logic [3:0] wr_b_log [$];
    logic [7:0] tx_log [$];
    int clr_cnt, start_cnt, err_size_cnt, tx_bad_start, tx_unstable;
    int ma [9];
    int mb [9];

    // environment state
    bit         tx_pend;
    int         tx_delay_cnt, tx_busy_cnt;
    logic [7:0] tx_hold;
    bit         calc_run;
    int         calc_cnt, env_s;

    always @(negedge bclk) begin
        if (rst) begin
            tx_busy_m   = 1'b0;
            tx_pend     = 1'b0;
            mult_done_m = 1'b0;
            calc_run    = 1'b0;
        end else begin
            if (bus.mem_clr) begin
                clr_cnt++;
                for (int i = 0; i < 9; i++) begin
                    mem_a[i] = 8'd0;
                    mem_b[i] = 8'd0;
                end
            end
            if (bus.mem_a_we) begin
                wr_a_log.push_back(bus.mem_addr);
                if (bus.mem_addr < 4'd9) mem_a[bus.mem_addr] = bus.rx_data;
            end
            if (bus.mem_b_we) begin
                wr_b_log.push_back(bus.mem_addr);
                if (bus.mem_addr < 4'd9) mem_b[bus.mem_addr] = bus.rx_data;
            end
            if (bus.err_size) err_size_cnt++;

            // Calculator: full 3x3 product of whatever the memories hold
            mult_done_m = 1'b0;
            if (bus.mult_start) begin
                start_cnt++;
                calc_run = 1'b1;
                calc_cnt = calc_delay;
            end else if (calc_run) begin
                if (calc_cnt == 0) begin
                    for (int k = 0; k < 9; k++) begin
                        env_s = 0;
                        for (int j = 0; j < 3; j++)
                            env_s += int'(mem_a[(k / 3) * 3 + j]) * int'(mem_b[j * 3 + k % 3]);
                        mult_result_m[k*16 +: 16] = 16'(env_s);
                    end
                    mult_done_m = 1'b1;
                    calc_run    = 1'b0;
                end else begin
                    calc_cnt--;
                end
            end

            // UART transmitter
            if ((tx_pend || tx_busy_m) && bus.tx_data !== tx_hold) tx_unstable++;
            if (bus.tx_start) begin
                if (tx_pend || tx_busy_m) tx_bad_start++;
                tx_hold = bus.tx_data;
                tx_log.push_back(bus.tx_data);
                tx_pend      = 1'b1;
                tx_delay_cnt = rise_delay;
            end
            if (tx_pend) begin
                if (tx_delay_cnt == 0) begin
                    tx_pend     = 1'b0;
                    tx_busy_m   = 1'b1;
                    tx_busy_cnt = busy_len;
                end else begin
                    tx_delay_cnt--;
                end
            end else if (tx_busy_m) begin
                tx_busy_cnt--;
                if (tx_busy_cnt <= 0) tx_busy_m = 1'b0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(posedge bclk); #1;
        rx_valid_m = 1'b1;
        rx_data_m  = b;
        @(posedge bclk); #1;
        rx_valid_m = 1'b0;
        repeat (gap) @(posedge bclk);
    endtask

    task automatic wait_state(input logic [2:0] st, input int budget, input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge bclk);
            if (bus.state == st) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            tests_run++;
            tests_failed++;
            $display("FAIL %s timeout: state=%0d required=%0d", name, bus.state, st);
        end
    endtask

    task automatic clear_logs();
        wr_a_log.delete();
        wr_b_log.delete();
        tx_log.delete();
        clr_cnt      = 0;
        start_cnt    = 0;
        tx_bad_start = 0;
        tx_unstable  = 0;
    endtask

    task automatic send_matrices(input int n);
        send_byte(8'(n), $urandom_range(0, 2));
        for (int i = 0; i < n * n; i++) send_byte(8'(ma[i]), $urandom_range(0, 2));
        for (int i = 0; i < n * n; i++) send_byte(8'(mb[i]), $urandom_range(0, 2));
    endtask

    task automatic check_session(input int n, input string name);
        logic [7:0] exp_tx [$];
        int         s, addr, r, c;
        logic [7:0] ea, eb;
        for (int i = 0; i < n * n; i++) begin
            s = 0;
            for (int j = 0; j < n; j++) s += ma[(i / n) * n + j] * mb[j * n + i % n];
            exp_tx.push_back(8'((s >> 8) & 255));
            exp_tx.push_back(8'(s & 255));
        end
        tests_run++;
        if (wr_a_log.size() != n * n || wr_b_log.size() != n * n) begin
            tests_failed++;
            $display("FAIL %s write_count: a=%0d b=%0d required=%0d", name, wr_a_log.size(), wr_b_log.size(), n * n);
        end
        for (int i = 0; i < n * n && i < wr_a_log.size() && i < wr_b_log.size(); i++) begin
            addr = (i / n) * 3 + (i % n);
            tests_run++;
            if (wr_a_log[i] !== 4'(addr) || wr_b_log[i] !== 4'(addr)) begin
                tests_failed++;
                $display("FAIL %s addr[%0d]: a=%0d b=%0d required=%0d", name, i, wr_a_log[i], wr_b_log[i], addr);
            end
        end
        for (int k = 0; k < 9; k++) begin
            r  = k / 3;
            c  = k % 3;
            ea = (r < n && c < n) ? 8'(ma[r * n + c]) : 8'd0;
            eb = (r < n && c < n) ? 8'(mb[r * n + c]) : 8'd0;
            tests_run++;
            if (mem_a[k] !== ea || mem_b[k] !== eb) begin
                tests_failed++;
                $display("FAIL %s mem[%0d]: a=%h b=%h required a=%h b=%h", name, k, mem_a[k], mem_b[k], ea, eb);
            end
        end
        tests_run++;
        if (clr_cnt != 1 || start_cnt != 1) begin
            tests_failed++;
            $display("FAIL %s pulses: mem_clr=%0d mult_start=%0d required 1 and 1", name, clr_cnt, start_cnt);
        end
        tests_run++;
        if (tx_log.size() != exp_tx.size()) begin
            tests_failed++;
            $display("FAIL %s tx_count: got %0d required %0d", name, tx_log.size(), exp_tx.size());
        end
        for (int i = 0; i < exp_tx.size() && i < tx_log.size(); i++) begin
            tests_run++;
            if (tx_log[i] !== exp_tx[i]) begin
                tests_failed++;
                $display("FAIL %s tx[%0d]: got %h required %h", name, i, tx_log[i], exp_tx[i]);
            end
        end
        tests_run++;
        if (tx_bad_start != 0 || tx_unstable != 0) begin
            tests_failed++;
            $display("FAIL %s handshake: bad_starts=%0d unstable_cycles=%0d required 0", name, tx_bad_start, tx_unstable);
        end
    endtask

    task automatic run_session(input int n, input string name);
        bit ok;
        clear_logs();
        send_matrices(n);
        wait_state(3'd0, 4000, name, ok);
        if (ok) check_session(n, name);
    endtask

    task automatic check_outputs_zero(input string name);
        logic [25:0] v;
        v = {bus.tx_start, bus.tx_data, bus.mem_clr, bus.mem_a_we, bus.mem_b_we, bus.mem_addr,
             bus.mult_start, bus.state, bus.matrix_size, bus.err_size, bus.err_overrun};
        tests_run++;
        if (v !== 26'd0) begin
            tests_failed++;
            $display("FAIL %s outputs: got %h required 0", name, v);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge bclk);
        #2;
        check_outputs_zero("reset");
        @(posedge bclk); #1;
        rst = 1'b0;
        @(negedge bclk);
        check_outputs_zero("after_reset");
    endtask

    task automatic test_size3();
        rise_delay = 0; busy_len = 2; calc_delay = 2;
        for (int i = 0; i < 9; i++) begin
            ma[i] = i + 1;
            mb[i] = (i % 4 == 0) ? 1 : 0;
        end
        run_session(3, "size3");
    endtask

    task automatic test_size2();
        rise_delay = 1; busy_len = 3; calc_delay = 0;
        ma[0] = 1; ma[1] = 2; ma[2] = 3; ma[3] = 4;
        mb[0] = 5; mb[1] = 6; mb[2] = 7; mb[3] = 8;
        run_session(2, "size2");
        tests_run++;
        if (tx_log.size() != 8 || tx_log[3] !== 8'h16 || tx_log[5] !== 8'h2B) begin
            tests_failed++;
            $display("FAIL size2_values: tx[3]=%h tx[5]=%h required 16 2b", tx_log[3], tx_log[5]);
        end
    endtask

    task automatic test_illegal_size();
        err_size_cnt = 0;
        send_byte(8'h00, 1);
        send_byte(8'h07, 1);
        repeat (2) @(negedge bclk);
        tests_run++;
        if (err_size_cnt != 2 || bus.state !== 3'd0) begin
            tests_failed++;
            $display("FAIL illegal_size: err_size pulses=%0d state=%0d required 2 and 0", err_size_cnt, bus.state);
        end
        ma[0] = 255; mb[0] = 255;
        run_session(1, "size1_ff");
        tests_run++;
        if (tx_log.size() != 2 || tx_log[0] !== 8'hFE || tx_log[1] !== 8'h01 || err_size_cnt != 2) begin
            tests_failed++;
            $display("FAIL size1_ff_values: count=%0d err_size=%0d required FE 01 with 2 pulses", tx_log.size(), err_size_cnt);
        end
    endtask

    task automatic test_slow_uart();
        rise_delay = 3; busy_len = 20; calc_delay = 4;
        for (int i = 0; i < 9; i++) begin
            ma[i] = $urandom_range(0, 255);
            mb[i] = $urandom_range(0, 255);
        end
        run_session(3, "slow_uart");
    endtask

    task automatic test_overrun();
        bit ok;
        rise_delay = 0; busy_len = 4; calc_delay = 8;
        for (int i = 0; i < 4; i++) begin
            ma[i] = $urandom_range(0, 255);
            mb[i] = $urandom_range(0, 255);
        end
        clear_logs();
        send_matrices(2);
        wait_state(3'd4, 100, "overrun_wait", ok);
        if (ok) begin
            send_byte(8'h55, 0);
            @(negedge bclk);
            tests_run++;
            if (bus.err_overrun !== 1'b1) begin
                tests_failed++;
                $display("FAIL overrun_set: got %b required 1", bus.err_overrun);
            end
            wait_state(3'd7, 200, "overrun_send", ok);
            tests_run++;
            if (bus.err_overrun !== 1'b1) begin
                tests_failed++;
                $display("FAIL overrun_sticky: got %b required 1", bus.err_overrun);
            end
            wait_state(3'd0, 2000, "overrun_done", ok);
            tests_run++;
            if (bus.err_overrun !== 1'b0) begin
                tests_failed++;
                $display("FAIL overrun_clear: got %b required 0", bus.err_overrun);
            end
            check_session(2, "overrun");
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 9; i++) begin
            ma[i] = $urandom_range(0, 255);
            mb[i] = $urandom_range(0, 255);
        end
        send_byte(8'd3, 1);
        for (int i = 0; i < 9; i++) send_byte(8'(ma[i]), 0);
        for (int i = 0; i < 4; i++) send_byte(8'(mb[i]), 0);
        @(negedge bclk);
        tests_run++;
        if (bus.state !== 3'd2) begin
            tests_failed++;
            $display("FAIL reset_mid_precond: state=%0d required 2", bus.state);
        end
        #2 rst = 1'b1;
        #1 check_outputs_zero("reset_mid");
        repeat (2) @(posedge bclk);
        #1 rst = 1'b0;
        rise_delay = 2; busy_len = 5; calc_delay = 3;
        ma[0] = $urandom_range(0, 255);
        mb[0] = $urandom_range(0, 255);
        run_session(1, "after_reset_mid");
    endtask

    task automatic test_random();
        int n;
        for (int t = 0; t < 5; t++) begin
            n          = $urandom_range(1, 3);
            rise_delay = $urandom_range(0, 3);
            busy_len   = $urandom_range(1, 6);
            calc_delay = $urandom_range(0, 5);
            for (int i = 0; i < 9; i++) begin
                ma[i] = $urandom_range(0, 255);
                mb[i] = $urandom_range(0, 255);
            end
            run_session(n, $sformatf("random%0d_n%0d", t, n));
        end
    endtask

    initial begin
        for (int i = 0; i < 9; i++) begin
            mem_a[i] = 8'd0;
            mem_b[i] = 8'd0;
        end
        test_reset();
        test_size3();
        test_size2();
        test_illegal_size();
        test_slow_uart();
        test_overrun();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
